// File: rtl/div_pkg.sv
// Shared widths and state encoding for the 16-by-8 restoring divider.
package div_pkg;

    localparam int unsigned DIVIDEND_W = 16;
    localparam int unsigned DIVISOR_W  = 8;
    localparam int unsigned REM_W      = DIVISOR_W + 1;
    localparam int unsigned CNT_W      = 4;

    typedef enum logic {
        IDLE = 1'b0,
        RUN  = 1'b1
    } state_t;

endpackage : div_pkg

// File: rtl/div_step.sv
// One radix-2 restoring iteration: shift in the next dividend bit, trial-subtract, restore.
module div_step
    import div_pkg::*;
(
    input  logic [DIVISOR_W-1:0]  rem,
    input  logic [DIVIDEND_W-1:0] q,
    input  logic [DIVISOR_W-1:0]  divisor,
    output logic [DIVISOR_W-1:0]  rem_next_c,
    output logic [DIVIDEND_W-1:0] q_next_c
);

    logic [REM_W-1:0]     t;
    logic                 ge;
    logic [DIVISOR_W-1:0] diff;

    // The partial remainder stays below the divisor, so when t >= divisor
    // the 9-bit difference always fits in 8 bits; the low byte is exact.
    always_comb begin
        t          = {rem, q[DIVIDEND_W-1]};
        ge         = (t >= {1'b0, divisor});
        diff       = t[DIVISOR_W-1:0] - divisor;
        rem_next_c = ge ? diff : t[DIVISOR_W-1:0];
        q_next_c   = {q[DIVIDEND_W-2:0], ge};
    end

endmodule : div_step

// File: rtl/restoring_div16by8.sv
// Sequential 16/8 unsigned restoring divider, one quotient bit per clock, start/done handshake.
module restoring_div16by8
    import div_pkg::*;
(
    input  logic                  clk,
    input  logic                  rst,
    input  logic                  start,
    input  logic [DIVIDEND_W-1:0] ain,
    input  logic [DIVISOR_W-1:0]  bin,
    output logic [DIVIDEND_W-1:0] quotient,
    output logic [DIVISOR_W-1:0]  remainder,
    output logic                  busy,
    output logic                  done,
    output logic                  dz
);

    state_t                state;
    logic [CNT_W-1:0]      cnt;
    logic [DIVISOR_W-1:0]  rem_r;
    logic [DIVIDEND_W-1:0] q_r;
    logic [DIVISOR_W-1:0]  divisor_r;
    logic [DIVISOR_W-1:0]  rem_n;
    logic [DIVIDEND_W-1:0] q_n;

    div_step u_step (
        .rem        (rem_r),
        .q          (q_r),
        .divisor    (divisor_r),
        .rem_next_c (rem_n),
        .q_next_c   (q_n)
    );

    // FSM, iteration counter, working registers and result registers
    always_ff @(posedge clk) begin
        if (rst) begin
            state     <= IDLE;
            cnt       <= '0;
            rem_r     <= '0;
            q_r       <= '0;
            divisor_r <= '0;
            quotient  <= '0;
            remainder <= '0;
            busy      <= 1'b0;
            done      <= 1'b0;
            dz        <= 1'b0;
        end else begin
            done <= 1'b0;
            case (state)
                IDLE: begin
                    if (start) begin
                        if (bin != '0) begin
                            rem_r     <= '0;
                            q_r       <= ain;
                            divisor_r <= bin;
                            cnt       <= CNT_W'(15);
                            busy      <= 1'b1;
                            dz        <= 1'b0;
                            state     <= RUN;
                        end else begin
                            // Divide by zero resolves immediately with saturated quotient
                            quotient  <= '1;
                            remainder <= ain[DIVISOR_W-1:0];
                            dz        <= 1'b1;
                            done      <= 1'b1;
                        end
                    end
                end
                RUN: begin
                    rem_r <= rem_n;
                    q_r   <= q_n;
                    cnt   <= cnt - CNT_W'(1);
                    if (cnt == '0) begin
                        quotient  <= q_n;
                        remainder <= rem_n;
                        done      <= 1'b1;
                        busy      <= 1'b0;
                        state     <= IDLE;
                    end
                end
                default: state <= IDLE;
            endcase
        end
    end

endmodule : restoring_div16by8

// File: tb/tb_restoring_div16by8.sv
// Directed and randomized checks of restoring_div16by8 against hand values and an 8x8 Vedic product.
module tb_restoring_div16by8;

    logic        clk = 1'b0;
    logic        rst;
    logic        start;
    logic [15:0] ain;
    logic [7:0]  bin;
    logic [15:0] quotient;
    logic [7:0]  remainder;
    logic        busy;
    logic        done;
    logic        dz;

    int checks = 0;
    int errors = 0;

    restoring_div16by8 dut (
        .clk       (clk),
        .rst       (rst),
        .start     (start),
        .ain       (ain),
        .bin       (bin),
        .quotient  (quotient),
        .remainder (remainder),
        .busy      (busy),
        .done      (done),
        .dz        (dz)
    );

    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        checks++;
        if (got !== exp) begin
            errors++;
            $display("FAIL %s got=%0h exp=%0h", tag, got, exp);
        end
    endtask

    // Urdhva-tiryagbhyam 8x8 product built from four 4x4 partial products
    function automatic logic [15:0] vedic8x8(input logic [7:0] a, input logic [7:0] b);
        logic [15:0] ll, lh, hl, hh;
        ll = 16'({4'b0, a[3:0]} * {4'b0, b[3:0]});
        lh = 16'({4'b0, a[3:0]} * {4'b0, b[7:4]});
        hl = 16'({4'b0, a[7:4]} * {4'b0, b[3:0]});
        hh = 16'({4'b0, a[7:4]} * {4'b0, b[7:4]});
        return (hh << 8) + ((lh + hl) << 4) + ll;
    endfunction

    // Issue one divide, wait for done; lat counts edges after the accepting edge
    task automatic run_div(input logic [15:0] a, input logic [7:0] b,
                           output logic [15:0] q, output logic [7:0] r, output logic d,
                           output int lat, output int busy_cyc);
        @(negedge clk);
        ain   = a;
        bin   = b;
        start = 1'b1;
        @(negedge clk);
        start    = 1'b0;
        lat      = 0;
        busy_cyc = 0;
        while (!done && lat < 40) begin
            if (busy) busy_cyc++;
            @(negedge clk);
            lat++;
        end
        if (!done) check("timeout", 32'(lat), 32'd16);
        q = quotient;
        r = remainder;
        d = dz;
        check("busy_at_done", 32'(busy), 32'd0);
        @(negedge clk);
        check("done_one_cycle", 32'(done), 32'd0);
        check("q_held", 32'(quotient), 32'(q));
    endtask

    logic [15:0] q;
    logic [7:0]  r;
    logic        d;
    int          lat, bcyc;

    typedef struct {
        logic [15:0] a;
        logic [7:0]  b;
        logic [15:0] q;
        logic [7:0]  r;
    } vec_t;

    vec_t vecs[8];

    initial begin
        rst = 1'b1; start = 1'b0; ain = '0; bin = '0;
        repeat (2) @(negedge clk);
        check("rst_quotient", 32'(quotient), 32'd0);
        check("rst_remainder", 32'(remainder), 32'd0);
        check("rst_busy", 32'(busy), 32'd0);
        check("rst_done", 32'(done), 32'd0);
        check("rst_dz", 32'(dz), 32'd0);
        rst = 1'b0;

        vecs[0] = '{16'd1000,  8'd7,   16'd142,   8'd6};
        vecs[1] = '{16'hFFFF,  8'd255, 16'd257,   8'd0};
        vecs[2] = '{16'd5,     8'd9,   16'd0,     8'd5};
        vecs[3] = '{16'd0,     8'd1,   16'd0,     8'd0};
        vecs[4] = '{16'hFFFF,  8'd1,   16'hFFFF,  8'd0};
        vecs[5] = '{16'd255,   8'd255, 16'd1,     8'd0};
        vecs[6] = '{16'hFFFF,  8'd2,   16'h7FFF,  8'd1};
        vecs[7] = '{16'h1234,  8'h10,  16'h0123,  8'd4};

        foreach (vecs[i]) begin
            run_div(vecs[i].a, vecs[i].b, q, r, d, lat, bcyc);
            check("vec_quotient", 32'(q), 32'(vecs[i].q));
            check("vec_remainder", 32'(r), 32'(vecs[i].r));
            check("vec_dz", 32'(d), 32'd0);
            check("vec_latency", 32'(lat), 32'd16);
            check("vec_busy_cycles", 32'(bcyc), 32'd16);
        end

        // Divide by zero
        run_div(16'd200, 8'd0, q, r, d, lat, bcyc);
        check("dz_quotient", 32'(q), 32'hFFFF);
        check("dz_remainder", 32'(r), 32'd200);
        check("dz_flag", 32'(d), 32'd1);
        check("dz_latency", 32'(lat), 32'd0);
        check("dz_busy_cycles", 32'(bcyc), 32'd0);
        check("dz_held", 32'(dz), 32'd1);
        run_div(16'd5, 8'd9, q, r, d, lat, bcyc);
        check("dz_cleared", 32'(d), 32'd0);

        // Start during RUN is ignored
        begin
            int pulses;
            logic [15:0] dq;
            logic [7:0]  dr;
            pulses = 0; dq = '0; dr = '0;
            @(negedge clk);
            ain = 16'd1000; bin = 8'd7; start = 1'b1;
            @(negedge clk);
            start = 1'b0;
            repeat (4) @(negedge clk);
            ain = 16'd50; bin = 8'd5; start = 1'b1;
            @(negedge clk);
            start = 1'b0;
            for (int i = 0; i < 30; i++) begin
                if (done) begin
                    pulses++;
                    dq = quotient;
                    dr = remainder;
                end
                @(negedge clk);
            end
            check("ign_pulses", 32'(pulses), 32'd1);
            check("ign_quotient", 32'(dq), 32'd142);
            check("ign_remainder", 32'(dr), 32'd6);
            check("ign_idle", 32'(busy), 32'd0);
        end

        // Reset mid-run
        @(negedge clk);
        ain = 16'd1000; bin = 8'd7; start = 1'b1;
        @(negedge clk);
        start = 1'b0;
        repeat (7) @(negedge clk);
        rst = 1'b1;
        @(negedge clk);
        rst = 1'b0;
        check("mid_rst_busy", 32'(busy), 32'd0);
        check("mid_rst_done", 32'(done), 32'd0);
        check("mid_rst_quotient", 32'(quotient), 32'd0);
        check("mid_rst_remainder", 32'(remainder), 32'd0);
        repeat (20) begin
            @(negedge clk);
            if (done) check("mid_rst_no_done", 32'(done), 32'd0);
        end
        run_div(16'h1234, 8'h10, q, r, d, lat, bcyc);
        check("post_rst_quotient", 32'(q), 32'h123);
        check("post_rst_remainder", 32'(r), 32'd4);

        // Back-to-back with start held high
        begin
            int n_done, t1, t2;
            logic [15:0] q1, q2;
            logic [7:0]  r1, r2;
            n_done = 0; t1 = 0; t2 = 0; q1 = '0; q2 = '0; r1 = '0; r2 = '0;
            @(negedge clk);
            ain = 16'h1234; bin = 8'h10; start = 1'b1;
            @(negedge clk);
            ain = 16'd300; bin = 8'd3;
            for (int i = 0; i < 60 && n_done < 2; i++) begin
                if (done) begin
                    n_done++;
                    if (n_done == 1) begin t1 = i; q1 = quotient; r1 = remainder; end
                    else begin t2 = i; q2 = quotient; r2 = remainder; end
                end
                if (n_done == 1 && i == t1 + 1) start = 1'b0;
                if (n_done == 1 && i == t1 + 5) check("b2b_held", 32'(quotient), 32'h123);
                @(negedge clk);
            end
            start = 1'b0;
            check("b2b_pulses", 32'(n_done), 32'd2);
            check("b2b_spacing", 32'(t2 - t1), 32'd17);
            check("b2b_q1", 32'(q1), 32'h123);
            check("b2b_r1", 32'(r1), 32'd4);
            check("b2b_q2", 32'(q2), 32'd100);
            check("b2b_r2", 32'(r2), 32'd0);
        end

        // Random vectors, cross-checked with the Vedic multiplier where it applies
        for (int i = 0; i < 1000; i++) begin
            logic [15:0] a;
            logic [7:0]  b;
            a = 16'($urandom);
            b = 8'($urandom_range(1, 255));
            run_div(a, b, q, r, d, lat, bcyc);
            check("rnd_quotient", 32'(q), 32'(a / 16'(b)));
            check("rnd_remainder", 32'(r), 32'(a % 16'(b)));
            if (q < 16'd256)
                check("rnd_vedic", 32'(vedic8x8(q[7:0], b)) + 32'(r), 32'(a));
        end

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule : tb_restoring_div16by8
